video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Frame/line sequencer for the display pipeline. It turns the programmed SFR timing fields (VSW/VBP/VACT/VFP, HSW/HBP/HACT/HFP) into VSYNC, HSYNC, DE and active-pixel coordinates. At every frame start it latches a shadow copy of the timing fields and holds it for the whole frame, so SFR writes take effect on the next VSYNC. It sits between the APB register file and the blur/mirror datapath, and its o_VSYNC is the frame strobe the SFR checker samples.

## Interface
- W, 16: width of every timing field and coordinate counter.
- i_CLK  in  1  clock.
- i_RST  in  1  reset, asynchronous, active-low.
- i_en  in  1  run request; level-sensitive.
- i_vsw, i_vbp, i_vact, i_vfp  in  W each  vertical phase lengths, in lines.
- i_hsw, i_hbp, i_hact, i_hfp  in  W each  horizontal phase lengths, in clocks.
- o_VSYNC  out  1  high for all cycles of the VSW lines.
- o_HSYNC  out  1  high during the HSW clocks of every line.
- o_DE  out  1  high when the horizontal and vertical phases are both ACT.
- o_x, o_y  out  W each  active pixel column and active line index; 0 when o_DE=0.
- o_frame_start  out  1  one-cycle pulse on the first cycle of a frame.
- o_line_start  out  1  one-cycle pulse on the first cycle of every line.
- o_busy  out  1  high while not IDLE.
- o_cfg_err  out  1  sticky; set when a latch attempt sees an invalid config.

## Operation
- Top states: IDLE and RUN. RUN contains two phase sequencers, H and V. Each sequencer steps SYNC -> BP -> ACT -> FP -> (wrap).
- The H phase counter advances every clock. The V phase counter advances only on the last clock of a line.
- A phase of length 0 is skipped: the sequencer moves straight to the next non-empty phase. BP and FP may be 0.
- A config is valid only if HSW, HACT, VSW and VACT are all nonzero.
- Latch attempt: the shadow registers are loaded from the i_* fields.
  - Valid: enter or continue RUN at V=SYNC, H=SYNC, with all counters at 0, and clear o_cfg_err.
  - Invalid: go to or stay in IDLE, set o_cfg_err, and leave the shadow registers unchanged.
- Latch attempts happen at the edge where i_en=1 is sampled in IDLE, and at the last clock of every frame while i_en=1.
- i_en=0 during RUN: the current frame completes. At the last clock of the frame the block goes to IDLE with no latch attempt. No frame is ever truncated.
- i_* changes during RUN have no effect until the next latch.
- Line length is HSW+HBP+HACT+HFP clocks. Frame length is VSW+VBP+VACT+VFP lines.
- Phase counters are W bits wide; each phase ends when its count equals len-1. No total-length counter is kept, so there is no overflow.
- o_x counts 0..HACT-1 within each active line. o_y counts 0..VACT-1 across the active lines.

## Timing
- All outputs are registered. Reset value of every output, counter and shadow register is 0, with state IDLE.
- Start latency is one edge: if i_en=1 is sampled in IDLE at edge k with a valid config, then after edge k o_VSYNC=o_HSYNC=o_frame_start=o_line_start=o_busy=1.
- Back-to-back frames with i_en held at 1 have no idle gap. o_frame_start repeats every (line length × frame length) clocks.
- In IDLE, o_VSYNC, o_HSYNC, o_DE, o_x, o_y and both pulse outputs are all 0.
- If the last clock of a frame coincides with i_en falling to 0, the block goes to IDLE: i_en is sampled at that edge only.
- An i_RST assertion mid-frame immediately forces IDLE and zero outputs. After release, a new frame needs an i_en sample.

## Structure
- Package video_timing_pkg holds:
  - typedef enum phase_t {PH_SYNC, PH_BP, PH_ACT, PH_FP};
  - struct timing_cfg_t with the four vertical and four horizontal W-bit fields;
  - function next_phase(), which returns the next phase with nonzero length.
- Sub-module vtg_phase_cnt contains one phase FSM plus its counter, with inputs i_adv, i_load and cfg lengths, and outputs phase, count and last. It is instantiated twice: H, advancing every clock, and V, advancing on the H last-of-line signal.

## Test plan
- Basic frame: HSW=2, HBP=1, HACT=4, HFP=1, VSW=1, VBP=1, VACT=2, VFP=1, i_en=1 -> line of 8 clocks, frame of 40 clocks; o_frame_start every 40 clocks; o_DE high 8 clocks per frame; o_x 0..3 and o_y 0..1; o_HSYNC high 2 of every 8 clocks.
- Zero porches: HBP=HFP=VBP=VFP=0 with the other fields as above -> line of 6 clocks, 3 lines; o_DE rises on the clock right after HSYNC falls.
- Shadow update: write HACT=6 mid-frame -> the current frame keeps 4-clock DE; the next frame, after o_frame_start, shows 6-clock DE and a 10-clock line.
- Invalid config: i_en=1 with VACT=0 -> stays IDLE, o_cfg_err=1, o_busy=0. Then VACT=2 -> starts one edge later and o_cfg_err clears.
- Graceful stop: drop i_en at clock 10 of the basic frame -> outputs continue to clock 39, then IDLE with o_busy=0 and no new o_frame_start.
- Reset mid-frame: assert i_RST at clock 20 -> all outputs 0 asynchronously. After release with i_en=1, o_frame_start fires one edge later.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared types for the video timing generator: phase encoding, timing config
// and the phase-skip helper used by both phase sequencers.
package video_timing_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_t;

  typedef struct packed {
    logic [W-1:0] vsw;
    logic [W-1:0] vbp;
    logic [W-1:0] vact;
    logic [W-1:0] vfp;
    logic [W-1:0] hsw;
    logic [W-1:0] hbp;
    logic [W-1:0] hact;
    logic [W-1:0] hfp;
  } timing_cfg_t;

  // Nearest following phase (cyclically) whose length is nonzero.
  function automatic phase_t next_phase(
    input phase_t       cur,
    input logic [W-1:0] len_sync,
    input logic [W-1:0] len_bp,
    input logic [W-1:0] len_act,
    input logic [W-1:0] len_fp
  );
    logic [3:0] nz;
    logic [1:0] p;
    phase_t     res;
    nz  = {len_fp != '0, len_act != '0, len_bp != '0, len_sync != '0};
    res = PH_SYNC;
    for (int i = 3; i >= 1; i--) begin
      p = 2'(cur) + 2'(i);
      if (nz[p]) res = phase_t'(p);
    end
    return res;
  endfunction

endpackage

// File: rtl/video_timing_gen_phase_cnt.sv
// One SYNC/BP/ACT/FP phase sequencer with its in-phase counter.
// i_load has priority and parks the sequencer at SYNC with count 0.
module vtg_phase_cnt
  import video_timing_pkg::*;
(
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         i_adv,
  input  logic         i_load,
  input  logic [W-1:0] i_len_sync,
  input  logic [W-1:0] i_len_bp,
  input  logic [W-1:0] i_len_act,
  input  logic [W-1:0] i_len_fp,
  output phase_t       phase,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] len_cur;
  phase_t       nxt;

  always_comb begin
    len_cur = i_len_sync;
    case (phase)
      PH_SYNC: len_cur = i_len_sync;
      PH_BP:   len_cur = i_len_bp;
      PH_ACT:  len_cur = i_len_act;
      PH_FP:   len_cur = i_len_fp;
      default: len_cur = i_len_sync;
    endcase
    last = (count == len_cur - W'(1));
    nxt  = next_phase(phase, i_len_sync, i_len_bp, i_len_act, i_len_fp);
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      phase <= PH_SYNC;
      count <= '0;
    end else if (i_load) begin
      phase <= PH_SYNC;
      count <= '0;
    end else if (i_adv) begin
      if (last) begin
        phase <= nxt;
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Frame/line sequencer: shadow-latched timing fields drive VSYNC/HSYNC/DE/x/y.
// Outputs decode registered state only; start latency is one edge after i_en.
module video_timing_gen
  import video_timing_pkg::*;
(
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         i_en,
  input  logic [W-1:0] i_vsw,
  input  logic [W-1:0] i_vbp,
  input  logic [W-1:0] i_vact,
  input  logic [W-1:0] i_vfp,
  input  logic [W-1:0] i_hsw,
  input  logic [W-1:0] i_hbp,
  input  logic [W-1:0] i_hact,
  input  logic [W-1:0] i_hfp,
  output logic         o_VSYNC,
  output logic         o_HSYNC,
  output logic         o_DE,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic         o_frame_start,
  output logic         o_line_start,
  output logic         o_busy,
  output logic         o_cfg_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state;
  timing_cfg_t  shadow;
  timing_cfg_t  cfg_in;
  logic         running;
  logic         cfg_ok;
  logic         latch_try;
  logic         line_end;
  logic         frame_end;
  logic         de;

  phase_t       h_ph;
  phase_t       v_ph;
  logic [W-1:0] h_cnt;
  logic [W-1:0] v_cnt;
  logic         h_last;
  logic         v_last;

  assign cfg_in = '{vsw: i_vsw, vbp: i_vbp, vact: i_vact, vfp: i_vfp,
                    hsw: i_hsw, hbp: i_hbp, hact: i_hact, hfp: i_hfp};

  assign running = (state == ST_RUN);
  assign cfg_ok  = (i_hsw != '0) && (i_hact != '0) && (i_vsw != '0) && (i_vact != '0);

  // The final phase of a line/frame is FP, or ACT when the front porch is empty.
  assign line_end  = running && h_last &&
                     (h_ph == ((shadow.hfp != '0) ? PH_FP : PH_ACT));
  assign frame_end = line_end && v_last &&
                     (v_ph == ((shadow.vfp != '0) ? PH_FP : PH_ACT));
  assign latch_try = i_en && (!running || frame_end);

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      o_cfg_err <= 1'b0;
    end else if (latch_try) begin
      if (cfg_ok) begin
        state     <= ST_RUN;
        shadow    <= cfg_in;
        o_cfg_err <= 1'b0;
      end else begin
        state     <= ST_IDLE;
        o_cfg_err <= 1'b1;
      end
    end else if (frame_end) begin
      state <= ST_IDLE;
    end
  end

  vtg_phase_cnt u_h (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_adv      (running),
    .i_load     (!running),
    .i_len_sync (shadow.hsw),
    .i_len_bp   (shadow.hbp),
    .i_len_act  (shadow.hact),
    .i_len_fp   (shadow.hfp),
    .phase      (h_ph),
    .count      (h_cnt),
    .last       (h_last)
  );

  vtg_phase_cnt u_v (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_adv      (line_end),
    .i_load     (!running),
    .i_len_sync (shadow.vsw),
    .i_len_bp   (shadow.vbp),
    .i_len_act  (shadow.vact),
    .i_len_fp   (shadow.vfp),
    .phase      (v_ph),
    .count      (v_cnt),
    .last       (v_last)
  );

  assign de = running && (h_ph == PH_ACT) && (v_ph == PH_ACT);

  always_comb begin
    o_busy        = running;
    o_VSYNC       = running && (v_ph == PH_SYNC);
    o_HSYNC       = running && (h_ph == PH_SYNC);
    o_DE          = de;
    o_x           = de ? h_cnt : '0;
    o_y           = de ? v_cnt : '0;
    o_line_start  = running && (h_ph == PH_SYNC) && (h_cnt == '0);
    o_frame_start = o_line_start && (v_ph == PH_SYNC) && (v_cnt == '0);
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: per-cycle comparison against a frame-position
// model (cycle index within frame -> line/column -> expected outputs).
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] vsw = '0, vbp = '0, vact = '0, vfp = '0;
  logic [15:0] hsw = '0, hbp = '0, hact = '0, hfp = '0;

  logic        vs, hs, de, fs, ls, busy, err;
  logic [15:0] x, y;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .i_CLK(clk), .i_RST(rst_n), .i_en(en),
    .i_vsw(vsw), .i_vbp(vbp), .i_vact(vact), .i_vfp(vfp),
    .i_hsw(hsw), .i_hbp(hbp), .i_hact(hact), .i_hfp(hfp),
    .o_VSYNC(vs), .o_HSYNC(hs), .o_DE(de), .o_x(x), .o_y(y),
    .o_frame_start(fs), .o_line_start(ls), .o_busy(busy), .o_cfg_err(err)
  );

  wire [38:0] obs = {busy, err, vs, hs, de, fs, ls, x, y};

  int checks = 0;
  int failures = 0;

  // Reference model: running flag, latched config, cycle index within frame.
  bit m_run = 0;
  bit m_err = 0;
  int m_t   = 0;
  int mc[8];   // vsw, vbp, vact, vfp, hsw, hbp, hact, hfp

  function automatic int line_len();
    return mc[4] + mc[5] + mc[6] + mc[7];
  endfunction

  function automatic int frame_len();
    return line_len() * (mc[0] + mc[1] + mc[2] + mc[3]);
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 0; m_t = 0;
    for (int i = 0; i < 8; i++) mc[i] = 0;
  endtask

  task automatic model_attempt();
    if (vsw != 0 && vact != 0 && hsw != 0 && hact != 0) begin
      mc[0] = vsw; mc[1] = vbp; mc[2] = vact; mc[3] = vfp;
      mc[4] = hsw; mc[5] = hbp; mc[6] = hact; mc[7] = hfp;
      m_run = 1; m_t = 0; m_err = 0;
    end else begin
      m_run = 0; m_err = 1;
    end
  endtask

  task automatic model_step();
    if (!m_run) begin
      if (en) model_attempt();
    end else if (m_t == frame_len() - 1) begin
      if (en) model_attempt();
      else m_run = 0;
    end else begin
      m_t++;
    end
  endtask

  function automatic logic [38:0] exp_vec();
    int l, line, col, ha0, va0, ex, ey;
    bit e_vs, e_hs, e_de;
    if (!m_run) return {1'b0, m_err, 37'b0};
    l    = line_len();
    line = m_t / l;
    col  = m_t % l;
    ha0  = mc[4] + mc[5];
    va0  = mc[0] + mc[1];
    e_vs = line < mc[0];
    e_hs = col < mc[4];
    e_de = (col >= ha0) && (col < ha0 + mc[6]) && (line >= va0) && (line < va0 + mc[2]);
    ex   = e_de ? col - ha0 : 0;
    ey   = e_de ? line - va0 : 0;
    return {1'b1, m_err, e_vs, e_hs, e_de, m_t == 0, col == 0, 16'(ex), 16'(ey)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int a, b, c, d, e, f, g, h);
    vsw = 16'(a); vbp = 16'(b); vact = 16'(c); vfp = 16'(d);
    hsw = 16'(e); hbp = 16'(f); hact = 16'(g); hfp = 16'(h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs !== 39'b0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, 39'b0);
    end
    rst_n = 1;
  endtask

  task automatic test_basic();
    int de_cnt = 0, hs_cnt = 0, fs_cnt = 0, xmax = 0, ymax = 0;
    do_reset();
    set_cfg(1, 1, 2, 1, 2, 1, 4, 1);
    en = 1;
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      de_cnt += int'(de); hs_cnt += int'(hs); fs_cnt += int'(fs);
      if (de && int'(x) > xmax) xmax = int'(x);
      if (de && int'(y) > ymax) ymax = int'(y);
    end
    checks++;
    if (de_cnt != 16 || hs_cnt != 20 || fs_cnt != 2 || xmax != 3 || ymax != 1) begin
      failures++;
      $display("FAIL basic_counts got de=%0d hs=%0d fs=%0d xmax=%0d ymax=%0d exp 16 20 2 3 1",
               de_cnt, hs_cnt, fs_cnt, xmax, ymax);
    end
  endtask

  task automatic test_zero_porch();
    int first_de = -1, fs_at = -1;
    do_reset();
    set_cfg(1, 0, 2, 0, 2, 0, 4, 0);
    en = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL zero_porch cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (de && first_de < 0) first_de = i;
      if (fs && i > 0 && fs_at < 0) fs_at = i;
    end
    checks++;
    if (first_de != 8 || fs_at != 18) begin
      failures++;
      $display("FAIL zero_porch_timing got first_de=%0d next_fs=%0d exp 8 18", first_de, fs_at);
    end
  endtask

  task automatic test_shadow();
    int de_f[3] = '{0, 0, 0};
    int fs_cnt = 0, ls1 = -1, ls2 = -1;
    do_reset();
    set_cfg(1, 1, 2, 1, 2, 1, 4, 1);
    en = 1;
    for (int i = 0; i < 90; i++) begin
      if (i == 5) hact = 16'd6;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL shadow cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (fs) fs_cnt++;
      if (fs_cnt >= 1 && fs_cnt <= 2) de_f[fs_cnt] += int'(de);
      if (fs_cnt == 2 && ls) begin
        if (ls1 < 0) ls1 = i;
        else if (ls2 < 0) ls2 = i;
      end
    end
    checks++;
    if (de_f[1] != 8 || de_f[2] != 12 || ls2 - ls1 != 10) begin
      failures++;
      $display("FAIL shadow_update got de1=%0d de2=%0d line=%0d exp 8 12 10",
               de_f[1], de_f[2], ls2 - ls1);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    set_cfg(1, 1, 0, 1, 2, 1, 4, 1);
    en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL invalid cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL invalid_idle got busy=%b err=%b exp 0 1", busy, err);
    end
    vact = 16'd2;
    tick();
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || fs !== 1'b1 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL invalid_recover got busy=%b err=%b fs=%b exp 1 0 1", busy, err, fs);
    end
  endtask

  task automatic test_stop();
    int busy_cnt = 0, fs_late = 0;
    do_reset();
    set_cfg(1, 1, 2, 1, 2, 1, 4, 1);
    en = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL stop cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      busy_cnt += int'(busy);
      if (fs && i > 0) fs_late++;
      if (i == 10) en = 0;
    end
    checks++;
    if (busy_cnt != 40 || fs_late != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_graceful got busy_cycles=%0d extra_fs=%0d busy=%b exp 40 0 0",
               busy_cnt, fs_late, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cfg(1, 1, 2, 1, 2, 1, 4, 1);
    en = 1;
    for (int i = 0; i < 21; i++) tick();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== 39'b0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs, 39'b0);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (fs !== 1'b1 || busy !== 1'b1 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL reset_mid_restart got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(2, 1), $urandom_range(2, 0), $urandom_range(3, 1), $urandom_range(2, 0),
            $urandom_range(3, 1), $urandom_range(2, 0), $urandom_range(5, 1), $urandom_range(2, 0));
    if ($urandom_range(9, 0) == 0) vact = 16'd0;
    if ($urandom_range(19, 0) == 0) hsw = 16'd0;
  endtask

  task automatic test_random();
    do_reset();
    set_cfg(2, 1, 3, 1, 3, 2, 5, 1);
    en = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39, 0) == 0) rand_cfg();
      if ($urandom_range(59, 0) == 0) en = ~en;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_zero_porch();
    test_shadow();
    test_invalid();
    test_stop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
